// File: rtl/evt_counter_bank.sv
// Bank of independent modulo-MAX_COUNT event counters with up/down, wrap/saturate,
// clear, clamped parallel load, registered rollover pulses and optional cascading.
module evt_counter_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 17,
  parameter int unsigned MAX_COUNT = 8000,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned CASCADE   = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_CH-1:0]        evt_in,
  input  logic [NUM_CH-1:0]        dir_in,
  input  logic [NUM_CH-1:0]        clear_in,
  input  logic [NUM_CH-1:0]        load_in,
  input  logic [WIDTH-1:0]         load_val_in,
  output logic [NUM_CH*WIDTH-1:0]  count_out,
  output logic [NUM_CH-1:0]        wrap_out,
  output logic [NUM_CH-1:0]        at_end_out
);

  localparam logic [WIDTH-1:0] LastVal = WIDTH'(MAX_COUNT - 1);

  // Shared clamped load value; when MAX_COUNT == 2**WIDTH nothing exceeds LastVal.
  logic [WIDTH-1:0] w_load_val;
  assign w_load_val = (load_val_in > LastVal) ? LastVal : load_val_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrap;
    logic             w_step;
    logic             w_at_end;
    logic             w_roll;

    if ((CASCADE != 0) && (i > 0)) begin : g_casc
      assign w_step = g_ch[i-1].w_roll;
    end else begin : g_evt
      assign w_step = evt_in[i];
    end

    assign w_at_end = dir_in[i] ? (r_count == '0) : (r_count == LastVal);
    // A step taken at the end value; clear and load suppress it.
    assign w_roll   = w_step & w_at_end & ~clear_in[i] & ~load_in[i];

    always_comb begin
      w_count_d = r_count;
      if (clear_in[i]) begin
        w_count_d = '0;
      end else if (load_in[i]) begin
        w_count_d = w_load_val;
      end else if (w_step) begin
        if (w_at_end) begin
          if (SATURATE == 0) begin
            w_count_d = dir_in[i] ? LastVal : '0;
          end
        end else begin
          w_count_d = dir_in[i] ? (r_count - 1'b1) : (r_count + 1'b1);
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_count <= w_count_d;
        r_wrap  <= w_roll;
      end
    end

    assign count_out[i*WIDTH +: WIDTH] = r_count;
    assign wrap_out[i]                 = r_wrap;
    assign at_end_out[i]               = w_at_end;
  end

endmodule

// File: tb/tb_evt_counter_bank.sv
// Directed-vector bench for evt_counter_bank: wrap, saturate and cascade builds side by side.
module tb_evt_counter_bank;
  localparam int NCH = 4;
  localparam int W   = 17;
  localparam int MAX = 8000;
  localparam int CW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    evt, dir, clr, ld;
  logic [W-1:0]  lval;
  logic [CW-1:0] cnt_w, cnt_s, cnt_c;
  logic [3:0]    wrap_w, wrap_s, wrap_c;
  logic [3:0]    end_w, end_s, end_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAX), .SATURATE(0), .CASCADE(0)) u_wrap (
    .clk_in(clk), .rst_in(rst), .evt_in(evt), .dir_in(dir), .clear_in(clr), .load_in(ld),
    .load_val_in(lval), .count_out(cnt_w), .wrap_out(wrap_w), .at_end_out(end_w)
  );

  evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1), .CASCADE(0)) u_sat (
    .clk_in(clk), .rst_in(rst), .evt_in(evt), .dir_in(dir), .clear_in(clr), .load_in(ld),
    .load_val_in(lval), .count_out(cnt_s), .wrap_out(wrap_s), .at_end_out(end_s)
  );

  evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAX), .SATURATE(0), .CASCADE(1)) u_casc (
    .clk_in(clk), .rst_in(rst), .evt_in(evt), .dir_in(dir), .clear_in(clr), .load_in(ld),
    .load_val_in(lval), .count_out(cnt_c), .wrap_out(wrap_c), .at_end_out(end_c)
  );

  typedef struct packed {
    logic          rst;
    logic [3:0]    evt, dir, clr, ld;
    logic [W-1:0]  lval;
    logic [CW-1:0] ea;
    logic [3:0]    wa, enda;
    logic [CW-1:0] eb;
    logic [3:0]    wb, endb;
  } vec_t;

  vec_t vq[$];

  function automatic logic [CW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  task automatic chk(input string nm, input logic [CW+3:0] got, input logic [CW+3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] d,
                       input logic [3:0] c, input logic [3:0] l, input int v);
    rst = r; evt = e; dir = d; clr = c; ld = l; lval = W'(v);
  endtask

  task automatic add(input logic r, input logic [3:0] e, input logic [3:0] d,
                     input logic [3:0] c, input logic [3:0] l, input int v,
                     input logic [CW-1:0] ea, input logic [3:0] wa, input logic [3:0] enda,
                     input logic [CW-1:0] eb, input logic [3:0] wb, input logic [3:0] endb);
    vec_t t;
    t.rst = r; t.evt = e; t.dir = d; t.clr = c; t.ld = l; t.lval = W'(v);
    t.ea = ea; t.wa = wa; t.enda = enda; t.eb = eb; t.wb = wb; t.endb = endb;
    vq.push_back(t);
  endtask

  // Random-phase reference state
  int ma[4], mb[4];
  logic [3:0] ewa, ewb;

  task automatic model_step(input int sat, inout int m[4], output logic [3:0] ew);
    for (int c = 0; c < 4; c++) begin
      bit atend;
      atend = dir[c] ? (m[c] == 0) : (m[c] == MAX - 1);
      ew[c] = 1'b0;
      if (rst) m[c] = 0;
      else if (clr[c]) m[c] = 0;
      else if (ld[c]) m[c] = (int'(lval) > MAX - 1) ? MAX - 1 : int'(lval);
      else if (evt[c]) begin
        ew[c] = atend;
        if (!(atend && sat != 0)) m[c] = dir[c] ? (m[c] + MAX - 1) % MAX : (m[c] + 1) % MAX;
      end
    end
    if (rst) ew = 4'b0000;
  endtask

  initial begin
    drive(1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 0);

    //   rst evt     dir     clr     ld      lval  wrap build: counts, wrap, at_end
    //                                             saturate build: counts, wrap, at_end
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(0, 0, 0, 0), 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0,
        pk(0, 7999, 0, 0), 4'b0010, 4'b0000, pk(0, 0, 0, 0), 4'b0010, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 9000,
        pk(0, 7999, 7999, 0), 4'b0000, 4'b0110, pk(0, 0, 7999, 0), 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 9000,
        pk(0, 7999, 0, 0), 4'b0000, 4'b0010, pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(0, 7999, 1, 0), 4'b0000, 4'b0010, pk(0, 0, 1, 0), 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7998,
        pk(7998, 7998, 7998, 7998), 4'b0000, 4'b0000,
        pk(7998, 7998, 7998, 7998), 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(7999, 7999, 7999, 7999), 4'b0000, 4'b1111,
        pk(7999, 7999, 7999, 7999), 4'b0000, 4'b1111);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(0, 0, 0, 0), 4'b1111, 4'b0000,
        pk(7999, 7999, 7999, 7999), 4'b1111, 4'b1111);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(0, 0, 0, 0), 4'b0000, 4'b0000,
        pk(7999, 7999, 7999, 7999), 4'b0000, 4'b1111);
    add(0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0,
        pk(0, 7999, 0, 7999), 4'b1010, 4'b0000,
        pk(7999, 7998, 7999, 7998), 4'b0000, 4'b0101);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8000,
        pk(7999, 7999, 0, 7999), 4'b0000, 4'b1011,
        pk(7999, 7998, 7999, 7998), 4'b0000, 4'b0101);
    add(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0,
        pk(0, 7999, 0, 7999), 4'b0000, 4'b1010,
        pk(0, 7998, 7999, 7998), 4'b0000, 4'b0100);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 123,
        pk(0, 123, 0, 7999), 4'b0000, 4'b1000,
        pk(0, 123, 7999, 7998), 4'b0000, 4'b0100);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(0, 0, 0, 0), 4'b0000, 4'b0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0,
        pk(1, 1, 1, 1), 4'b0000, 4'b0000, pk(1, 1, 1, 1), 4'b0000, 4'b0000);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].evt, vq[i].dir, vq[i].clr, vq[i].ld, int'(vq[i].lval));
      tick();
      chk($sformatf("v%0d wrap_cnt", i), {4'b0, cnt_w}, {4'b0, vq[i].ea});
      chk($sformatf("v%0d wrap_pulse", i), {{CW{1'b0}}, wrap_w}, {{CW{1'b0}}, vq[i].wa});
      chk($sformatf("v%0d wrap_end", i), {{CW{1'b0}}, end_w}, {{CW{1'b0}}, vq[i].enda});
      chk($sformatf("v%0d sat_cnt", i), {4'b0, cnt_s}, {4'b0, vq[i].eb});
      chk($sformatf("v%0d sat_pulse", i), {{CW{1'b0}}, wrap_s}, {{CW{1'b0}}, vq[i].wb});
      chk($sformatf("v%0d sat_end", i), {{CW{1'b0}}, end_s}, {{CW{1'b0}}, vq[i].endb});
    end

    // Full-range up count on channel 0: exactly one rollover, landing on 0.
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    for (int n = 1; n <= MAX; n++) begin
      tick();
      chk($sformatf("full_run n=%0d", n), {wrap_w, cnt_w},
          {(n == MAX) ? 4'b0001 : 4'b0000, pk(n % MAX, 0, 0, 0)});
    end

    // Cascade ripple, chain break by clear, ignored evt on upper channel, full ripple.
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 7999);
    tick();
    drive(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 5);
    tick();
    chk("casc_preload", {wrap_c, cnt_c}, {4'b0000, pk(7999, 7999, 5, 0)});
    drive(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    chk("casc_ripple", {wrap_c, cnt_c}, {4'b0011, pk(0, 0, 6, 0)});
    drive(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    chk("casc_pulse_end", {wrap_c, cnt_c}, {4'b0000, pk(0, 0, 6, 0)});
    drive(0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 7999);
    tick();
    drive(0, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 0);
    tick();
    chk("casc_break", {wrap_c, cnt_c}, {4'b0001, pk(0, 0, 6, 0)});
    drive(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    chk("casc_evt_ignored", {wrap_c, cnt_c}, {4'b0000, pk(0, 0, 6, 0)});
    drive(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7999);
    tick();
    drive(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    chk("casc_full_ripple", {wrap_c, cnt_c}, {4'b1111, pk(0, 0, 0, 0)});

    // Reset mid-count with events held high.
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    for (int n = 0; n < 5; n++) tick();
    chk("midrst_before", {wrap_w, cnt_w}, {4'b0000, pk(5, 5, 5, 5)});
    rst = 1'b1;
    tick();
    chk("midrst_during", {wrap_w, cnt_w}, {4'b0000, pk(0, 0, 0, 0)});
    rst = 1'b0;
    tick();
    chk("midrst_resume", {wrap_w, cnt_w}, {4'b0000, pk(1, 1, 1, 1)});

    // Random traffic against the reference on the wrap and saturate builds.
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      ma[c] = 0;
      mb[c] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      evt  = 4'($urandom);
      dir  = 4'($urandom);
      clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ld   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      lval = ($urandom_range(0, 3) == 0) ? W'($urandom_range(MAX - 3, 9000))
                                         : W'($urandom_range(0, MAX + 100));
      model_step(0, ma, ewa);
      model_step(1, mb, ewb);
      tick();
      chk($sformatf("rand_wrap n=%0d", n), {wrap_w, cnt_w}, {ewa, pk(ma[0], ma[1], ma[2], ma[3])});
      chk($sformatf("rand_sat n=%0d", n), {wrap_s, cnt_s}, {ewb, pk(mb[0], mb[1], mb[2], mb[3])});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
